axi4_min_initiator: RTL and testbench

- Initiator (master) end of the team's minimal AXI-style switch/LED bus.
- Accepts one read or write command at a time from a local command port.
- Sequences the address, read and write handshakes toward the memory responder, then returns read data or a status code with a per-phase timeout.
- Sits between board switch/button debounce logic and the responder that drives the 7-segment display.

---
 rtl/axi_min_pkg.sv | 30 +++
 rtl/axi_min_phase_timer.sv | 47 ++++
 rtl/axi4_min_initiator.sv | 204 ++++++++++++++++++++
 tb/tb_axi4_min_initiator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_min_pkg.sv
//------------------------------------------------------------------------------
// Module   : axi_min_pkg
// Purpose  : Shared types and constants for the minimal AXI-style initiator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package axi_min_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;
    localparam int RDATA_W = 8;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_BADADDR = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_RCAP = 3'd3,
        ST_AW   = 3'd4,
        ST_W    = 3'd5,
        ST_DONE = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/axi_min_phase_timer.sv
//------------------------------------------------------------------------------
// Module   : axi_min_phase_timer
// Purpose  : Per-phase watchdog; counts cycles spent in one handshake phase
//            and flags when the phase has lasted TIMEOUT_CYCLES cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_min_phase_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Clear wins over count so a fresh phase always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires during the last permitted cycle of the phase.
    assign expired = en && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/axi4_min_initiator.sv
//------------------------------------------------------------------------------
// Module   : axi4_min_initiator
// Purpose  : Single-outstanding command initiator for the switch/LED bus.
//            Sequences AR/R or AR/AW/W handshakes and reports a status code.
// Options  : AXI_INIT_RETRY_EN - one automatic retry from AR after a timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi4_min_initiator
    import axi_min_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    output logic               rsp_valid,
    output logic [1:0]         rsp_err,
    output logic [RDATA_W-1:0] rsp_rdata,
    output logic               busy,
    output logic               ms_arvalid,
    output logic [ADDR_W-1:0]  SWM_arADDR,
    input  logic               sm_arready,
    output logic               ms_rready,
    input  logic               sm_rvalid,
    input  logic [RDATA_W-1:0] disp_hex_r,
    output logic               ms_awvalid,
    input  logic               sm_awready,
    output logic               ms_wvalid,
    output logic [DATA_W-1:0]  SWM_wdata,
    input  logic               sm_wready
);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic [RDATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]           err_q, err_d;
`ifdef AXI_INIT_RETRY_EN
    logic                 retry_q, retry_d;
`endif

    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;
    logic abort;

    assign tmr_en = (state_q == ST_AR) || (state_q == ST_R) ||
                    (state_q == ST_AW) || (state_q == ST_W);

    axi_min_phase_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Next-state, capture and status logic; handshakes take priority over timeout.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        abort   = 1'b0;
        tmr_clr = 1'b0;
`ifdef AXI_INIT_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    write_d = cmd_write;
`ifdef AXI_INIT_RETRY_EN
                    retry_d = 1'b0;
`endif
                    if (cmd_write && (cmd_addr == '0)) begin
                        err_d   = ERR_BADADDR;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_AR;
                    end
                end
            end
            ST_AR: begin
                if (sm_arready) begin
                    state_d = write_q ? ST_AW : ST_R;
                end else if (tmr_expired) begin
                    abort = 1'b1;
                end
            end
            ST_R: begin
                if (sm_rvalid) begin
                    state_d = ST_RCAP;
                end else if (tmr_expired) begin
                    abort = 1'b1;
                end
            end
            ST_RCAP: begin
                // Responder data is registered, so it is valid one cycle after the R beat.
                rdata_d = disp_hex_r;
                err_d   = ERR_OK;
                state_d = ST_DONE;
            end
            ST_AW: begin
                if (sm_awready) begin
                    state_d = ST_W;
                end else if (tmr_expired) begin
                    abort = 1'b1;
                end
            end
            ST_W: begin
                if (sm_wready) begin
                    err_d   = ERR_OK;
                    state_d = ST_DONE;
                end else if (tmr_expired) begin
                    abort = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
`ifdef AXI_INIT_RETRY_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                state_d = ST_AR;
                // Re-entry may be AR->AR, which is not seen as a state change.
                tmr_clr = 1'b1;
            end else begin
                err_d   = ERR_TIMEOUT;
                state_d = ST_DONE;
            end
`else
            err_d   = ERR_TIMEOUT;
            state_d = ST_DONE;
`endif
        end

        if (state_d != state_q) begin
            tmr_clr = 1'b1;
        end
    end

    // State and transaction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
`ifdef AXI_INIT_RETRY_EN
            retry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef AXI_INIT_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    // Bus and response outputs are pure state decodes.
    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_err    = err_q;
    assign rsp_rdata  = rdata_q;
    assign ms_arvalid = (state_q == ST_AR) || (state_q == ST_R);
    assign ms_rready  = (state_q == ST_R);
    assign ms_awvalid = (state_q == ST_AW) || (state_q == ST_W);
    assign ms_wvalid  = (state_q == ST_W);
    assign SWM_arADDR = addr_q;
    assign SWM_wdata  = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_axi4_min_initiator.sv
//------------------------------------------------------------------------------
// Module   : tb_axi4_min_initiator
// Purpose  : Directed self-checking bench for axi4_min_initiator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi4_min_initiator;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_wdata;
    logic       rsp_valid;
    logic [1:0] rsp_err;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       ms_arvalid;
    logic [3:0] SWM_arADDR;
    logic       sm_arready;
    logic       ms_rready;
    logic       sm_rvalid;
    logic [7:0] disp_hex_r;
    logic       ms_awvalid;
    logic       sm_awready;
    logic       ms_wvalid;
    logic [3:0] SWM_wdata;
    logic       sm_wready;

    // Responder model: zero-wait when its enable is set, silent otherwise.
    logic ar_en, r_en, aw_en, w_en;
    assign sm_arready = ar_en & ms_arvalid;
    assign sm_rvalid  = r_en  & ms_rready;
    assign sm_awready = aw_en & ms_awvalid;
    assign sm_wready  = w_en  & ms_wvalid;

    int checks = 0;
    int errors = 0;

    axi4_min_initiator #(
        .TIMEOUT_CYCLES (16),
        .TO_W           (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .ms_arvalid (ms_arvalid),
        .SWM_arADDR (SWM_arADDR),
        .sm_arready (sm_arready),
        .ms_rready  (ms_rready),
        .sm_rvalid  (sm_rvalid),
        .disp_hex_r (disp_hex_r),
        .ms_awvalid (ms_awvalid),
        .sm_awready (sm_awready),
        .ms_wvalid  (ms_wvalid),
        .SWM_wdata  (SWM_wdata),
        .sm_wready  (sm_wready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] bus_vec();
        return {ms_arvalid, ms_rready, ms_awvalid, ms_wvalid};
    endfunction

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'd0; cmd_wdata = 4'd0;
        disp_hex_r = 8'h49; ar_en = 1'b1; r_en = 1'b1; aw_en = 1'b1; w_en = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_bus", bus_vec(), 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("rst_addr", {SWM_arADDR, SWM_wdata}, 0);

        // Read addr 5, responder returns 8'h49
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd5; cmd_wdata = 4'd0;
        tick(); cmd_valid = 1'b0;
        chk("rd_ar", {ms_arvalid, ms_rready, busy, cmd_ready}, 4'b1010);
        chk("rd_addr", SWM_arADDR, 5);
        tick();
        chk("rd_r", {ms_arvalid, ms_rready, rsp_valid}, 3'b110);
        tick();
        chk("rd_cap", {bus_vec(), rsp_valid}, 0);
        tick();
        chk("rd_done", {rsp_valid, rsp_err}, 3'b100);
        chk("rd_data", rsp_rdata, 8'h49);
        tick();
        chk("rd_idle", {rsp_valid, busy, cmd_ready}, 3'b001);
        chk("rd_hold", rsp_rdata, 8'h49);

        // Write addr 3, wdata 7
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd3; cmd_wdata = 4'd7;
        tick(); cmd_valid = 1'b0;
        chk("wr_ar", bus_vec(), 4'b1000);
        chk("wr_lat", {SWM_arADDR, SWM_wdata}, 8'h37);
        tick();
        chk("wr_aw", bus_vec(), 4'b0010);
        chk("wr_aw_addr", SWM_arADDR, 3);
        tick();
        chk("wr_w", bus_vec(), 4'b0011);
        chk("wr_w_addr", SWM_arADDR, 3);
        tick();
        chk("wr_done", {rsp_valid, rsp_err, bus_vec()}, 7'b1000000);
        chk("wr_rdata_kept", rsp_rdata, 8'h49);
        tick();
        chk("wr_idle", rsp_valid, 0);

        // Write addr 0 is rejected without bus activity
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd0; cmd_wdata = 4'd2;
        tick(); cmd_valid = 1'b0;
        chk("bad_done", {rsp_valid, rsp_err, bus_vec()}, 7'b1100000);
        tick();
        chk("bad_idle", {rsp_valid, bus_vec(), cmd_ready}, 6'b000001);

        // AW never acknowledged: timeout after 16 cycles in AW
        aw_en = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd2; cmd_wdata = 4'd1;
        tick(); cmd_valid = 1'b0;
        chk("to_ar", bus_vec(), 4'b1000);
        tick();
        chk("to_aw0", bus_vec(), 4'b0010);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_aw_wait", {ms_awvalid, rsp_valid}, 2'b10);
        end
`ifdef AXI_INIT_RETRY_EN
        tick();
        chk("to_retry_ar", {bus_vec(), rsp_valid}, 5'b10000);
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_retry_wait", {ms_awvalid, rsp_valid}, 2'b10);
        end
`endif
        tick();
        chk("to_done", {rsp_valid, rsp_err, bus_vec()}, 7'b1010000);
        chk("to_rdata_kept", rsp_rdata, 8'h49);
        tick();
        chk("to_idle", {rsp_valid, bus_vec(), cmd_ready}, 6'b000001);
        aw_en = 1'b1;

        // Reset while in W
        w_en = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd4; cmd_wdata = 4'd9;
        tick(); cmd_valid = 1'b0;
        tick();
        tick();
        chk("rw_in_w", bus_vec(), 4'b0011);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_bus", bus_vec(), 0);
        chk("rw_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("rw_state", {busy, cmd_ready}, 2'b01);
        chk("rw_addr", {SWM_arADDR, SWM_wdata}, 0);
        w_en = 1'b1;

        // cmd_valid held through a read: next accept only after rsp_valid
        disp_hex_r = 8'h3C;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd6; cmd_wdata = 4'd0;
        tick();
        chk("hold_accept", {busy, ms_arvalid, SWM_arADDR}, 6'b11_0110);
        tick(); tick(); tick();
        chk("hold_done", {rsp_valid, rsp_err, cmd_ready}, 4'b1000);
        chk("hold_data", rsp_rdata, 8'h3C);
        tick();
        chk("hold_gap", {busy, cmd_ready, rsp_valid, bus_vec()}, 7'b0100000);
        disp_hex_r = 8'hA5;
        tick();
        cmd_valid = 1'b0;
        chk("hold_second", {busy, ms_arvalid}, 2'b11);
        tick(); tick(); tick();
        chk("hold_done2", {rsp_valid, rsp_rdata}, 9'h1A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
